// File: rtl/fetch_buffer.sv
// Fetch buffer: decouples instruction memory requests from decode with a tag FIFO
// for in-flight fetches and a data FIFO for returned instructions. Option: FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  PCEnF,
    input  logic                  FlushD,
    input  logic                  StallD,
    output logic                  ImemReqValid,
    input  logic                  ImemReqReady,
    output logic [DATA_WIDTH-1:0] ImemAddr,
    input  logic                  ImemRespValid,
    input  logic [DATA_WIDTH-1:0] ImemRespData,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_tag_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_tag_pc4   [DEPTH];
    logic [DATA_WIDTH-1:0] r_dat_instr [DEPTH];
    logic [DATA_WIDTH-1:0] r_dat_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_dat_pc4   [DEPTH];
    logic [PW-1:0]         r_tag_wr, r_tag_rd, r_dat_wr, r_dat_rd;
    logic [CW-1:0]         r_inflight, r_count, r_drop;
    logic [DATA_WIDTH-1:0] r_hold_instr, r_hold_pc, r_hold_pc4;

    logic                  w_req_fire, w_resp, w_keep, w_bypass, w_push, w_pop;
    logic                  w_valid;
    logic [CW:0]           w_occ;
    logic [DATA_WIDTH-1:0] w_instr, w_pc, w_pc4;
    logic                  w_unused;

    assign w_unused     = ^PCF[1:0];
    assign w_occ        = {1'b0, r_inflight} + {1'b0, r_count};
    assign ImemAddr     = {PCF[DATA_WIDTH-1:2], 2'b00};
    // Credit check uses only registered occupancy: a pop this cycle frees nothing yet.
    assign ImemReqValid = !reset && !FlushD && (w_occ < {1'b0, DEPTH_C});
    assign w_req_fire   = ImemReqValid && ImemReqReady;
    assign PCEnF        = !reset && (w_req_fire || FlushD);
    assign w_resp       = ImemRespValid && !reset;
    assign w_keep       = w_resp && (r_drop == '0) && !FlushD;
`ifdef FETCH_BUFFER_BYPASS_EN
    assign w_bypass     = w_keep && (r_count == '0);
    assign w_push       = w_keep && (!w_bypass || StallD);
`else
    assign w_bypass     = 1'b0;
    assign w_push       = w_keep;
`endif
    assign w_pop        = !reset && !FlushD && (r_count != '0) && !StallD;

    always_comb begin
        w_valid = 1'b0;
        w_instr = r_hold_instr;
        w_pc    = r_hold_pc;
        w_pc4   = r_hold_pc4;
        if (reset) begin
            w_instr = '0;
            w_pc    = '0;
            w_pc4   = '0;
        end else if (r_count != '0) begin
            w_valid = 1'b1;
            w_instr = r_dat_instr[r_dat_rd];
            w_pc    = r_dat_pc[r_dat_rd];
            w_pc4   = r_dat_pc4[r_dat_rd];
        end else if (w_bypass) begin
            w_valid = 1'b1;
            w_instr = ImemRespData;
            w_pc    = r_tag_pc[r_tag_rd];
            w_pc4   = r_tag_pc4[r_tag_rd];
        end
    end

    assign ValidD   = w_valid;
    assign InstrD   = w_instr;
    assign PCD      = w_pc;
    assign PCPlus4D = w_pc4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_wr     <= '0;
            r_tag_rd     <= '0;
            r_dat_wr     <= '0;
            r_dat_rd     <= '0;
            r_inflight   <= '0;
            r_count      <= '0;
            r_drop       <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_hold_pc4   <= '0;
        end else begin
            if (w_req_fire) begin
                r_tag_pc[r_tag_wr]  <= PCF;
                r_tag_pc4[r_tag_wr] <= PCPlus4F;
                r_tag_wr            <= r_tag_wr + PW'(1);
            end
            if (w_resp) begin
                r_tag_rd <= r_tag_rd + PW'(1);
            end
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_resp);

            // Everything still in flight after this cycle is stale and must be discarded.
            if (FlushD) begin
                r_drop <= r_inflight - CW'(w_resp);
            end else if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end

            if (FlushD) begin
                r_count  <= '0;
                r_dat_rd <= r_dat_wr;
            end else begin
                if (w_push) begin
                    r_dat_instr[r_dat_wr] <= ImemRespData;
                    r_dat_pc[r_dat_wr]    <= r_tag_pc[r_tag_rd];
                    r_dat_pc4[r_dat_wr]   <= r_tag_pc4[r_tag_rd];
                    r_dat_wr              <= r_dat_wr + PW'(1);
                end
                if (w_pop) begin
                    r_dat_rd <= r_dat_rd + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end

            r_hold_instr <= w_instr;
            r_hold_pc    <= w_pc;
            r_hold_pc4   <= w_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_push && (r_count == DEPTH_C)));
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: PC-stage and variable-latency memory models plus an
// in-order PC scoreboard on every decode handshake.
module tb_fetch_buffer;
    localparam logic [31:0] KEY = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF, PCPlus4F;
    logic        PCEnF, FlushD, StallD;
    logic        ImemReqValid, ImemReqReady;
    logic [31:0] ImemAddr;
    logic        ImemRespValid;
    logic [31:0] ImemRespData;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    always #5 clk = ~clk;

    fetch_buffer #(.DATA_WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PCPlus4F(PCPlus4F), .PCEnF(PCEnF),
        .FlushD(FlushD), .StallD(StallD), .ImemReqValid(ImemReqValid),
        .ImemReqReady(ImemReqReady), .ImemAddr(ImemAddr), .ImemRespValid(ImemRespValid),
        .ImemRespData(ImemRespData), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_dlv = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          mark;
    logic [31:0] exp_next;
    logic [31:0] flush_tgt;
    logic [31:0] q_addr[$];
    int          q_due[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge; samples the cycle, advances one clock, returns at the next negedge.
    task automatic tick();
        logic        s_req, s_pcen, s_flush;
        logic [31:0] s_addr;
        #1;
        s_req   = ImemReqValid && ImemReqReady;
        s_addr  = ImemAddr;
        s_pcen  = PCEnF;
        s_flush = FlushD;
        if (!reset && !FlushD && ValidD && !StallD) begin
            chk("dlv_pc", PCD, exp_next);
            chk("dlv_pc4", PCPlus4D, exp_next + 32'd4);
            chk("dlv_instr", InstrD, exp_next ^ KEY);
            exp_next = exp_next + 32'd4;
            n_dlv++;
        end
        if (s_flush) exp_next = flush_tgt;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            q_addr.delete();
            q_due.delete();
        end
        if (s_req) begin
            q_addr.push_back(s_addr);
            q_due.push_back(cyc + lat - 1);
        end
        if (s_pcen) begin
            PCF      = s_flush ? flush_tgt : PCF + 32'd4;
            PCPlus4F = PCF + 32'd4;
        end
        ImemRespValid = 1'b0;
        ImemRespData  = '0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            ImemRespValid = 1'b1;
            ImemRespData  = q_addr.pop_front() ^ KEY;
            void'(q_due.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; PCF = 32'hbfc00000; PCPlus4F = 32'hbfc00004;
        FlushD = 1'b0; StallD = 1'b0; ImemReqReady = 1'b1;
        ImemRespValid = 1'b0; ImemRespData = '0;
        flush_tgt = '0; exp_next = 32'hbfc00000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_reqv", 32'(ImemReqValid), 32'd0);
        chk("rst_pcen", 32'(PCEnF), 32'd0);
        chk("rst_valid", 32'(ValidD), 32'd0);
        chk("rst_instr", InstrD, 32'd0);
        chk("rst_pcd", PCD, 32'd0);
        chk("rst_pc4", PCPlus4D, 32'd0);
        chk("rst_count", 32'(dut.r_count), 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);

        // First fetch after reset
        chk("c0_reqv", 32'(ImemReqValid), 32'd1);
        chk("c0_addr", ImemAddr, 32'hbfc00000);
        chk("c0_pcen", 32'(PCEnF), 32'd1);
        chk("c0_valid", 32'(ValidD), 32'd0);
        tick();
`ifdef FETCH_BUFFER_BYPASS_EN
        chk("c1_valid", 32'(ValidD), 32'd1);
        chk("c1_pcd", PCD, 32'hbfc00000);
        chk("c1_pc4", PCPlus4D, 32'hbfc00004);
`else
        chk("c1_valid", 32'(ValidD), 32'd0);
        tick();
        chk("c2_valid", 32'(ValidD), 32'd1);
        chk("c2_pcd", PCD, 32'hbfc00000);
        chk("c2_pc4", PCPlus4D, 32'hbfc00004);
`endif

        // Steady stream, 1-cycle memory
        repeat (8) tick();
        chk("seq_count", 32'(n_dlv >= 3), 32'd1);

        // Decode stall saturates the buffer
        StallD = 1'b1;
        repeat (4) tick();
        chk("stl_count", 32'(dut.r_count), 32'd2);
        chk("stl_reqv", 32'(ImemReqValid), 32'd0);
        chk("stl_pcen", 32'(PCEnF), 32'd0);
        chk("stl_valid", 32'(ValidD), 32'd1);
        chk("stl_pcd", PCD, exp_next);
        tick();
        StallD = 1'b0;
        mark = n_dlv;
        repeat (6) tick();
        chk("stl_resume", 32'(n_dlv >= mark + 2), 32'd1);

        // Flush with two requests in flight
        lat = 3;
        for (int k = 0; k < 30 && !(dut.r_inflight == 2 && dut.r_count == 0 && !ImemRespValid); k++) tick();
        chk("fl_setup", 32'(dut.r_inflight == 2 && dut.r_count == 0 && !ImemRespValid), 32'd1);
        flush_tgt = 32'hbfc00100;
        FlushD = 1'b1;
        #1;
        chk("fl_reqv", 32'(ImemReqValid), 32'd0);
        chk("fl_pcen", 32'(PCEnF), 32'd1);
        tick();
        FlushD = 1'b0;
        chk("fl_valid", 32'(ValidD), 32'd0);
        chk("fl_drop", 32'(dut.r_drop), 32'd2);
        for (int k = 0; k < 30 && !ValidD; k++) tick();
        chk("fl_first_valid", 32'(ValidD), 32'd1);
        chk("fl_first_pc", PCD, 32'hbfc00100);

        // Request channel back-pressure
        ImemReqReady = 1'b0;
        for (int k = 0; k < 30 && !(dut.r_inflight == 0 && dut.r_count == 0); k++) tick();
        chk("rdy_setup", 32'(dut.r_inflight == 0 && dut.r_count == 0), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("rdy_reqv", 32'(ImemReqValid), 32'd1);
            chk("rdy_addr", ImemAddr, {PCF[31:2], 2'b00});
            chk("rdy_pcen", 32'(PCEnF), 32'd0);
            tick();
        end

        // Flush coinciding with the only in-flight response
        ImemReqReady = 1'b1;
        tick();
        ImemReqReady = 1'b0;
        for (int k = 0; k < 30 && !ImemRespValid; k++) tick();
        chk("fr_setup", 32'(ImemRespValid && dut.r_inflight == 1), 32'd1);
        flush_tgt = 32'hbfc00200;
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        chk("fr_drop", 32'(dut.r_drop), 32'd0);
        chk("fr_valid", 32'(ValidD), 32'd0);
        ImemReqReady = 1'b1;
        for (int k = 0; k < 30 && !ValidD; k++) tick();
        chk("fr_first_valid", 32'(ValidD), 32'd1);
        chk("fr_first_pc", PCD, 32'hbfc00200);

        // Reset mid-operation
        repeat (3) tick();
        reset = 1'b1;
        PCF = 32'hbfc00000; PCPlus4F = 32'hbfc00004; exp_next = 32'hbfc00000;
        #1;
        chk("mr_reqv", 32'(ImemReqValid), 32'd0);
        chk("mr_pcen", 32'(PCEnF), 32'd0);
        chk("mr_valid", 32'(ValidD), 32'd0);
        chk("mr_pcd", PCD, 32'd0);
        tick();
        chk("mr_inflight", 32'(dut.r_inflight), 32'd0);
        chk("mr_count", 32'(dut.r_count), 32'd0);
        chk("mr_drop", 32'(dut.r_drop), 32'd0);
        lat = 1;
        reset = 1'b0;
        mark = n_dlv;
        repeat (6) tick();
        chk("mr_resume", 32'(n_dlv >= mark + 2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the instruction, address and PC width.
REQ-002 SHALL have parameter DEPTH, default 2, legal values 2 or 4, giving the buffer entries and the maximum number of outstanding requests.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 PCF, PCPlus4F  in  DATA_WIDTH each  current fetch PC and PC+4 from the PC stage.
REQ-006 PCEnF  out  1  PC stage enable; the PC advances or loads its redirect target when high.
REQ-007 FlushD  in  1  redirect: discard all buffered and in-flight fetches.
REQ-008 StallD  in  1  decode cannot accept an instruction this cycle.
REQ-009 ImemReqValid  out  1; ImemReqReady  in  1; ImemAddr  out  DATA_WIDTH  instruction memory request channel.
REQ-010 ImemRespValid  in  1; ImemRespData  in  DATA_WIDTH  instruction memory response channel; in-order, no backpressure, minimum latency 1 cycle.
REQ-011 InstrD, PCD, PCPlus4D  out  DATA_WIDTH each; ValidD  out  1  decode-side instruction, its PC and PC+4, and the valid flag.

Function
REQ-012 ImemAddr SHALL equal {PCF[DATA_WIDTH-1:2], 2'b00}.
REQ-013 ImemReqValid SHALL be high iff reset=0, FlushD=0 and (inflight + count) < DEPTH, where inflight and count are the current-cycle register values and a same-cycle pop gives no credit.
REQ-014 A request SHALL be accepted when ImemReqValid & ImemReqReady; on acceptance, PCF/PCPlus4F SHALL be pushed into a DEPTH-entry tag FIFO and inflight SHALL increment.
REQ-015 PCEnF SHALL be (ImemReqValid & ImemReqReady) | FlushD, held low during reset.
REQ-016 Each ImemRespValid pulse SHALL pop the tag FIFO and decrement inflight.
REQ-017 If drop > 0, the response SHALL be discarded and drop decremented; otherwise {data, PC, PC+4} SHALL be pushed into the data FIFO and count incremented.
REQ-018 Outputs SHALL present the data FIFO head; ValidD = (count != 0).
REQ-019 A pop SHALL occur when ValidD & !StallD.
REQ-020 A simultaneous push and pop SHALL leave count unchanged.
REQ-021 When count = 0, InstrD/PCD/PCPlus4D SHALL hold their last values.
REQ-022 FlushD SHALL have priority over push, pop and request in its cycle.
REQ-023 On FlushD, count SHALL be 0 next cycle.
REQ-024 On FlushD, drop SHALL become inflight minus 1 if a response arrives in the same cycle, else inflight; a flush during a non-zero drop SHALL apply the same rule.
REQ-025 Requests SHALL resume the cycle after FlushD, while drop is non-zero; stale responses are consumed first because responses are in-order.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 inflight, count and drop SHALL never exceed DEPTH.
REQ-028 A push to the data FIFO when full SHALL be impossible by REQ-013 and SHALL be flagged by a simulation assertion.

Reset
REQ-029 While reset=1: ImemReqValid=0, PCEnF=0, ValidD=0, InstrD=0, PCD=0, PCPlus4D=0, all FIFO pointers, inflight, count and drop = 0.
REQ-030 Reset mid-operation SHALL drop all in-flight state; responses arriving during or after reset for pre-reset requests are outside scope, and the memory SHALL be reset together with this block.

Configuration
REQ-031 With macro FETCH_BUFFER_BYPASS_EN defined, a response arriving with count = 0, drop = 0 and FlushD = 0 SHALL drive InstrD/PCD/PCPlus4D and ValidD=1 in the same cycle.
REQ-032 Under FETCH_BUFFER_BYPASS_EN, that response SHALL be written to the data FIFO only if StallD=1.
REQ-033 Without FETCH_BUFFER_BYPASS_EN, every response SHALL be written to the data FIFO and appear on ValidD one cycle after ImemRespValid, with no combinational path from Imem response inputs to decode outputs.

Verification
REQ-034 Reset release with PCF=0xbfc00000 and Ready=1 -> first cycle ImemReqValid=1, ImemAddr=0xbfc00000, PCEnF=1; with 1-cycle memory, ValidD=1, PCD=0xbfc00000, PCPlus4D=0xbfc00004 (1 cycle later without bypass).
REQ-035 Steady 1-cycle memory, StallD=0, DEPTH=2 -> PCD sequence 0xbfc00000, 0xbfc00004, 0xbfc00008, no duplicates or gaps.
REQ-036 StallD held high for 5 cycles -> count saturates at 2, ImemReqValid=0, PCEnF=0, PCD held; on release, the next two PCs are delivered in order.
REQ-037 FlushD with inflight=2, next PCF=0xbfc00100 -> ValidD=0 next cycle, two stale responses discarded, first ValidD carries PCD=0xbfc00100.
REQ-038 FlushD in the same cycle as ImemRespValid with inflight=1 -> that response is dropped, drop=0, and the next response is delivered.
REQ-039 ImemReqReady=0 for 3 cycles -> ImemReqValid stays 1, ImemAddr is stable, PCEnF=0, PCF is unchanged.
